// File: rtl/btn_enc_pkg.sv
// Shared sizes and FSM state encoding for the front-panel selection encoder.
package btn_enc_pkg;
  localparam int NUM_BTN = 16;
  localparam int CODE_W  = 4;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, SEND, WAIT_REL} state_t;
endpackage

// File: rtl/pri_enc164.sv
// 16-to-4 priority encoder, highest set index wins; purely combinational.
// Also flags any-set and more-than-one-set for the caller.
module pri_enc164
  import btn_enc_pkg::*;
(
  input  logic [NUM_BTN-1:0] in,
  output logic [CODE_W-1:0]  code,
  output logic               any,
  output logic               multi
);

  always_comb begin
    code = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (in[i]) code = CODE_W'(i);
    end
  end

  assign any = |in;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = (in & (in - NUM_BTN'(1))) != '0;

endmodule

// File: rtl/btn_enc164.sv
// Button synchronizer, debouncer and valid/ready code reporter; valid rises DEBOUNCE_CYCLES+2 edges after a press,
// holds until accepted, re-arms after a debounced release. Optional BTN_ENC_MULTI_ERR_EN rejects multi-button presses.
module btn_enc164
  import btn_enc_pkg::*;
#(
  parameter  int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn,
  output logic [CODE_W-1:0]  code,
  output logic               valid,
  input  logic               ready,
`ifdef BTN_ENC_MULTI_ERR_EN
  output logic               multi_err,
`endif
  output logic               busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] s1, btn_s, cand, cand_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CODE_W-1:0]  code_n, enc_code;
  logic               valid_n, merr_n;
  logic               cand_any_unused;
  state_t             state, state_n;

`ifdef BTN_ENC_MULTI_ERR_EN
  logic enc_multi;
`else
  logic enc_multi_unused;
`endif

  pri_enc164 u_enc (
    .in    (cand),
    .code  (enc_code),
    .any   (cand_any_unused),
`ifdef BTN_ENC_MULTI_ERR_EN
    .multi (enc_multi)
`else
    .multi (enc_multi_unused)
`endif
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= '0;
      btn_s <= '0;
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
      code  <= '0;
      valid <= 1'b0;
`ifdef BTN_ENC_MULTI_ERR_EN
      multi_err <= 1'b0;
`endif
    end else begin
      s1    <= btn;
      btn_s <= s1;
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
      code  <= code_n;
      valid <= valid_n;
`ifdef BTN_ENC_MULTI_ERR_EN
      multi_err <= merr_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    code_n  = code;
    valid_n = valid;
    merr_n  = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s != '0) begin
          cand_n  = btn_s;
          cnt_n   = '0;
          state_n = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (btn_s == '0) begin
          state_n = IDLE;
        end else if (btn_s != cand) begin
          cand_n = btn_s;
          cnt_n  = '0;
        end else if (cnt == CNT_LAST) begin
`ifdef BTN_ENC_MULTI_ERR_EN
          if (enc_multi) begin
            merr_n  = 1'b1;
            cnt_n   = '0;
            state_n = WAIT_REL;
          end else begin
            code_n  = enc_code;
            valid_n = 1'b1;
            state_n = SEND;
          end
`else
          code_n  = enc_code;
          valid_n = 1'b1;
          state_n = SEND;
`endif
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      SEND: begin
        // Buttons are ignored here; only the handshake moves us on.
        if (ready) begin
          valid_n = 1'b0;
          cnt_n   = '0;
          state_n = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (btn_s != '0) begin
          cnt_n = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_btn_enc164.sv
// Directed bench for btn_enc164 at DEBOUNCE_CYCLES=4: press latency, glitch, priority, backpressure, release bounce, reset.
module tb_btn_enc164;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic [15:0] btn;
  logic [3:0]  code;
  logic        valid;
  logic        busy;
`ifdef BTN_ENC_MULTI_ERR_EN
  logic        multi_err;
`endif

  int          ncmp = 0;
  int          nfail = 0;
  int          vcount, vfirst, ecount, bc;
  logic [3:0]  vcode;

  btn_enc164 dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .code      (code),
    .valid     (valid),
    .ready     (ready),
`ifdef BTN_ENC_MULTI_ERR_EN
    .multi_err (multi_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step n edges; tally valid cycles, first valid edge index and code seen while valid.
  task automatic run(input int n);
    vcount = 0;
    vfirst = 0;
    ecount = 0;
    vcode  = '0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (valid === 1'b1) begin
        vcount++;
        if (vfirst == 0) vfirst = k;
        vcode = code;
      end
`ifdef BTN_ENC_MULTI_ERR_EN
      if (multi_err === 1'b1) ecount++;
`endif
    end
  endtask

  initial begin
    reset = 1'b1;
    btn   = '0;
    ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", valid, 0);
    chk("rst_code", code, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // single press
    btn = 16'h0020;
    run(20);
    chk("t1_count", vcount, 1);
    chk("t1_first", vfirst, 7);
    chk("t1_code", vcode, 5);
    chk("t1_busy_held", busy, 1);
    btn = '0;
    run(12);
    chk("t1_rel_novalid", vcount, 0);
    chk("t1_rel_busy", busy, 0);
    chk("t1_code_hold", code, 5);

    // glitch shorter than debounce
    btn = 16'h0100;
    run(3);
    chk("t2_busy_deb", busy, 1);
    chk("t2_novalid_a", vcount, 0);
    btn = '0;
    run(3);
    chk("t2_novalid_b", vcount, 0);
    chk("t2_busy_back", busy, 0);

    // multi-press
    btn = 16'h8001;
    run(12);
`ifdef BTN_ENC_MULTI_ERR_EN
    chk("t3_novalid", vcount, 0);
    chk("t3_merr_pulses", ecount, 1);
    chk("t3_merr_low", multi_err, 0);
`else
    chk("t3_count", vcount, 1);
    chk("t3_code", vcode, 15);
`endif
    btn = '0;
    run(12);
    chk("t3_rel_busy", busy, 0);

    // backpressure
    ready = 1'b0;
    btn = 16'h0004;
    run(8);
    chk("t4_first", vfirst, 7);
    chk("t4_count_a", vcount, 2);
    chk("t4_valid", valid, 1);
    chk("t4_code", code, 2);
    btn = '0;
    run(6);
    chk("t4_held", vcount, 6);
    chk("t4_held_code", vcode, 2);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("t4_hs_valid", valid, 0);
    chk("t4_hs_busy", busy, 1);
    run(10);
    chk("t4_no_more", vcount, 0);
    chk("t4_idle", busy, 0);
    ready = 1'b1;

    // release bounce
    btn = 16'h0020;
    run(8);
    chk("t5_press", vcount, 1);
    bc = 0;
    for (int i = 0; i < 12; i++) begin
      btn = (((i / 2) % 2) == 1) ? 16'h0020 : 16'h0000;
      tick();
      if (valid === 1'b1) bc++;
    end
    chk("t5_bounce_novalid", bc, 0);
    chk("t5_bounce_busy", busy, 1);
    btn = '0;
    run(6);
    chk("t5_rel_novalid", vcount, 0);
    chk("t5_rel_idle", busy, 0);
    btn = 16'h0001;
    run(12);
    chk("t5_new_count", vcount, 1);
    chk("t5_new_first", vfirst, 7);
    chk("t5_new_code", vcode, 0);

    // reset while debouncing
    btn = '0;
    run(12);
    btn = 16'h0040;
    run(4);
    chk("t6a_pre_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6a_valid", valid, 0);
    chk("t6a_code", code, 0);
    chk("t6a_busy", busy, 0);
    run(12);
    chk("t6a_count", vcount, 1);
    chk("t6a_first", vfirst, 7);
    chk("t6a_vcode", vcode, 6);

    // reset while sending under backpressure
    btn = '0;
    run(12);
    ready = 1'b0;
    btn = 16'h0200;
    run(8);
    chk("t6b_pre_valid", valid, 1);
    chk("t6b_pre_code", code, 9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6b_valid", valid, 0);
    chk("t6b_code", code, 0);
    chk("t6b_busy", busy, 0);
    ready = 1'b1;
    run(12);
    chk("t6b_count", vcount, 1);
    chk("t6b_first", vfirst, 7);
    chk("t6b_vcode", vcode, 9);
    btn = '0;
    run(12);
    chk("t6b_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/btn_enc164.md
Name: btn_enc164

Overview:
Front-panel selection encoder for the vending machine, the inverse of the 4-to-16 selection decoder. It takes 16 raw product-select buttons and synchronizes and debounces them. It priority-encodes a stable press into a 4-bit product code and hands that code to the vend controller over a valid/ready handshake. It reports once per press and re-arms only after all buttons are released.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a press and to accept a release (>=1); top level overrides for real hardware.
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, never overridden.

Ports:
clk  in  1  single clock for all logic.
reset  in  1  synchronous, active-high reset.
btn  in  16  raw asynchronous buttons, active-high, bit i = product i.
code  out  4  encoded product index; held stable while valid.
valid  out  1  code is available.
ready  in  1  consumer accepts code on a clk edge where valid && ready.
busy  out  1  high in every FSM state except IDLE.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). Nothing resets asynchronously.
- Reset values: code=0, valid=0, busy=0, synchronizer flops=0, counter=0, FSM=IDLE. Reset mid-operation abandons any pending code without a handshake. A button held through reset is debounced anew and reported once.
- Synchronizer: two flops, btn -> s1 -> btn_s. All FSM decisions use btn_s only.
- FSM states: IDLE, DEBOUNCE, SEND, WAIT_REL.
- IDLE: if btn_s != 0, capture cand=btn_s, cnt=0, go to DEBOUNCE.
- DEBOUNCE:
  - btn_s==0: go to IDLE.
  - btn_s nonzero but != cand: recapture cand, cnt=0.
  - btn_s==cand and cnt==DEBOUNCE_CYCLES-1: register code=highest set index of cand, set valid=1, go to SEND.
  - Otherwise: cnt++.
- SEND: valid=1, code frozen. On valid && ready, clear valid at that edge and go to WAIT_REL with cnt=0. Button changes are ignored while in SEND.
- WAIT_REL: btn_s==0 increments cnt. Any nonzero btn_s clears cnt. When cnt reaches DEBOUNCE_CYCLES-1 with btn_s==0, go to IDLE.
- Latency: if btn first samples a constant press at edge N, valid is high after edge N+2+DEBOUNCE_CYCLES (N+6 at default).
- Handshake:
  - With ready tied high, valid is exactly 1 cycle wide.
  - ready is ignored when valid=0.
  - valid never drops without a handshake, except on reset.
- Priority: with multiple buttons pressed, the highest index wins (e.g. 16'h8001 gives code=15).
- code retains its last value after the handshake; consumers must qualify it with valid.

Optional Feature:
BTN_ENC_MULTI_ERR_EN
- Defined:
  - Adds output port multi_err (1 bit, reset 0).
  - At debounce completion, if cand has more than one bit set, no valid is raised. Instead multi_err pulses high for one cycle and the FSM goes directly to WAIT_REL.
  - Single-bit presses behave as in the base design.
- Undefined: port absent; multi-bit presses are priority-encoded as described above.

Decomposition:
- Package btn_enc_pkg holds:
  - NUM_BTN=16 and CODE_W=4.
  - State enum typedef state_t {IDLE, DEBOUNCE, SEND, WAIT_REL}.
- One sub-module, pri_enc164: combinational 16-to-4 highest-index priority encoder. It outputs code[3:0], plus any (OR of inputs) and multi (more than one bit set), which is used only under the macro.
- The synchronizer, counter and FSM stay in btn_enc164.

Test Plan:
- Single press: DEBOUNCE_CYCLES=4, ready=1, btn=16'h0020 held 20 cycles. Expect valid high for exactly one cycle at edge N+6 with code=5, and no second valid while the button is held.
- Glitch: btn=16'h0100 for 3 cycles, then 0. Expect no valid, and busy returns to 0 within 2 cycles after btn_s clears.
- Multi-press: btn=16'h8001 held.
  - Without the macro: code=15, valid once.
  - With BTN_ENC_MULTI_ERR_EN: one-cycle multi_err pulse, valid stays 0.
- Backpressure: ready=0, btn=16'h0004 pressed 8 cycles then released. Expect valid=1 and code=2 held steady. Then ready=1 for 1 cycle: exactly one handshake, valid=0 next cycle, no further code.
- Release bounce: after a handshake on 16'h0020, btn toggles between 0 and 16'h0020 every 2 cycles for 12 cycles. Expect no new valid. Then btn=0 for 6 cycles followed by 16'h0001: code=0 accepted as a new press.
- Reset mid-operation: reset asserted 1 cycle while in DEBOUNCE, and separately while in SEND with ready=0. Expect valid=0, code=0, busy=0 after that edge. With btn still held, exactly one new valid at N+6 counted from the first post-reset edge.
